dmem_arbiter: RTL and testbench

//  Shares the single data memory between two requesters: M0 = core load/store

---
 rtl/dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the core load/store port
// (M0) and the debug/loader port (M1). One access is granted per cycle. Alignment
// and range are checked. Each granted access produces one registered completion
// pulse with its read data or error flag. A requester can hold a lock for
// back-to-back accesses. A starvation counter breaks a lock that has been held
// too long.
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration in IDLE.
// When it is undefined, M0 has fixed priority over M1.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DMEM_SIZE  = 1024,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_lock,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [2:0]            m0_rd,
  input  logic [1:0]            m0_wr,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_lock,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [2:0]            m1_rd,
  input  logic [1:0]            m1_wr,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [2:0]            dmem_rd,
  output logic [1:0]            dmem_wr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int                  WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_MAX   = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0]   WAIT_ONE   = WAIT_W'(1);
  localparam logic [ADDR_WIDTH:0] SIZE_LIMIT = (ADDR_WIDTH + 1)'(DMEM_SIZE);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait0;
  logic [WAIT_W-1:0] wait1;
  logic [WAIT_W-1:0] wait0_nxt;
  logic [WAIT_W-1:0] wait1_nxt;
  logic              bad0;
  logic              bad1;
  logic              starve0;
  logic              starve1;

`ifdef DMEM_ARB_RR_EN
  // 1 means M1 was granted most recently, so M0 wins the next tie.
  logic last_gnt;
`endif

  // Transfer size in bytes for a 2-bit size code. Code 00 means no transfer.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Reject a misaligned half/word access, or any access that runs past the end
  // of memory. The sum is one bit wider so that addresses near the top of the
  // address space cannot wrap around and pass the range check.
  function automatic logic access_bad(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [1:0]            size);
    logic [ADDR_WIDTH:0] end_addr;
    logic                misaligned;
    end_addr   = {1'b0, addr} + {{(ADDR_WIDTH - 2){1'b0}}, size_bytes(size)};
    misaligned = (size == 2'b10 && addr[0]) ||
                 (size == 2'b11 && addr[1:0] != 2'b00);
    return (size != 2'b00) && (misaligned || end_addr > SIZE_LIMIT);
  endfunction

  // Validate each port's pending command. Read and write are never both
  // nonzero, so OR-ing the two size fields gives the access size.
  always_comb begin
    bad0    = access_bad(m0_addr, m0_rd[1:0] | m0_wr);
    bad1    = access_bad(m1_addr, m1_rd[1:0] | m1_wr);
    starve0 = (wait0 == WAIT_MAX);
    starve1 = (wait1 == WAIT_MAX);
  end

  // Grant selection. A lock owner has exclusive access. In IDLE, a starving
  // port goes ahead of normal priority. Nothing is granted while reset is
  // asserted, so no memory command can escape during the reset cycle.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      case (state)
        OWN0: m0_gnt = m0_req;
        OWN1: m1_gnt = m1_req;
        default: begin
          if (m0_req && m1_req) begin
            if (starve0) begin
              m0_gnt = 1'b1;
            end else if (starve1) begin
              m1_gnt = 1'b1;
            end else begin
`ifdef DMEM_ARB_RR_EN
              m0_gnt = last_gnt;
              m1_gnt = !last_gnt;
`else
              m0_gnt = 1'b1;
`endif
            end
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
      endcase
    end
  end

  // Starvation counters count blocked request cycles, saturate at the
  // limit, and clear on grant.
  always_comb begin
    wait0_nxt = wait0;
    wait1_nxt = wait1;
    if (m0_gnt) begin
      wait0_nxt = '0;
    end else if (m0_req && !starve0) begin
      wait0_nxt = wait0 + WAIT_ONE;
    end
    if (m1_gnt) begin
      wait1_nxt = '0;
    end else if (m1_req && !starve1) begin
      wait1_nxt = wait1 + WAIT_ONE;
    end
  end

  // Ownership transitions. A lock ends when the owner's last access is
  // unlocked, when the owner goes idle, or when the other port has starved.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_gnt && m0_lock) begin
          state_nxt = OWN0;
        end else if (m1_gnt && m1_lock) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_req || (m0_gnt && !m0_lock) ||
            (m1_req && wait1_nxt == WAIT_MAX)) begin
          state_nxt = IDLE;
        end
      end
      OWN1: begin
        if (!m1_req || (m1_gnt && !m1_lock) ||
            (m0_req && wait0_nxt == WAIT_MAX)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Drive the memory command from the granted port. A rejected access keeps
  // its address on the bus but issues no read or write.
  always_comb begin
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_rd    = 3'b000;
    dmem_wr    = 2'b00;
    if (m0_gnt) begin
      dmem_addr  = m0_addr;
      dmem_wdata = m0_wdata;
      if (!bad0) begin
        dmem_rd = m0_rd;
        dmem_wr = m0_wr;
      end
    end else if (m1_gnt) begin
      dmem_addr  = m1_addr;
      dmem_wdata = m1_wdata;
      if (!bad1) begin
        dmem_rd = m1_rd;
        dmem_wr = m1_wr;
      end
    end
  end

  // Arbitration state, starvation counters and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wait0 <= '0;
      wait1 <= '0;
`ifdef DMEM_ARB_RR_EN
      last_gnt <= 1'b1;
`endif
    end else begin
      state <= state_nxt;
      wait0 <= wait0_nxt;
      wait1 <= wait1_nxt;
`ifdef DMEM_ARB_RR_EN
      if (m0_gnt) begin
        last_gnt <= 1'b0;
      end else if (m1_gnt) begin
        last_gnt <= 1'b1;
      end
`endif
    end
  end

  // Completion pulse, error flag and read data for each port, one cycle after
  // its grant. A granted write, no-op or rejected access returns zero data.
  // An ungranted port keeps its last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt;
      m0_err    <= m0_gnt && bad0;
      if (m0_gnt) begin
        m0_rdata <= (!bad0 && m0_rd[1:0] != 2'b00) ? dmem_rdata : '0;
      end
      m1_rvalid <= m1_gnt;
      m1_err    <= m1_gnt && bad1;
      if (m1_gnt) begin
        m1_rdata <= (!bad1 && m1_rd[1:0] != 2'b00) ? dmem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-array memory,
// a transaction-level reference model, and a per-cycle compare process.
// Define DMEM_ARB_RR_EN to check the round-robin build.
module tb_dmem_arbiter;

  localparam int MEMSZ = 1024;
  localparam int MAXW  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_rd, m1_rd;
  logic [1:0]  m0_wr, m1_wr;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [2:0]  dmem_rd;
  logic [1:0]  dmem_wr;

  logic [7:0]  mem     [0:MEMSZ-1];
  logic [7:0]  ref_mem [0:MEMSZ-1];

  int checks = 0;
  int errors = 0;

  // Reference model state: current lock owner (-1 = none), wait counts,
  // last granted port, and the expected registered outputs.
  int          m_owner;
  int          m_wait [2];
  int          m_last;
  logic        m_rvalid [2];
  logic        m_err    [2];
  logic [31:0] m_rdata  [2];
  bit          model_ready = 1'b0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  // Memory: combinational read of the addressed bytes, with optional sign
  // extension. Writes happen at the clock edge.
  always_comb begin
    int          a;
    int          n;
    logic [31:0] v;
    a = int'(dmem_addr % 32'd1024);
    n = nbytes(dmem_rd[1:0]);
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < n) v[8*i +: 8] = mem[(a + i) % MEMSZ];
    end
    if (dmem_rd[2] && n == 1 && v[7])  v[31:8]  = '1;
    if (dmem_rd[2] && n == 2 && v[15]) v[31:16] = '1;
    dmem_rdata = v;
  end

  always @(posedge clk) begin
    int a;
    int n;
    a = int'(dmem_addr % 32'd1024);
    n = nbytes(dmem_wr);
    for (int i = 0; i < 4; i++) begin
      if (i < n) mem[(a + i) % MEMSZ] <= dmem_wdata[8*i +: 8];
    end
  end

  function automatic logic req_of(input int k);
    return (k == 0) ? m0_req : m1_req;
  endfunction
  function automatic logic lock_of(input int k);
    return (k == 0) ? m0_lock : m1_lock;
  endfunction
  function automatic logic [31:0] addr_of(input int k);
    return (k == 0) ? m0_addr : m1_addr;
  endfunction
  function automatic logic [31:0] wdata_of(input int k);
    return (k == 0) ? m0_wdata : m1_wdata;
  endfunction
  function automatic logic [2:0] rd_of(input int k);
    return (k == 0) ? m0_rd : m1_rd;
  endfunction
  function automatic logic [1:0] wr_of(input int k);
    return (k == 0) ? m0_wr : m1_wr;
  endfunction

  // A command is rejected if its address is not a multiple of its size, or
  // if it extends past the end of memory.
  function automatic bit is_err(input int k);
    logic [2:0] rd;
    int         n;
    longint     a;
    rd = rd_of(k);
    n  = nbytes(rd[1:0] | wr_of(k));
    a  = 0;
    a[31:0] = addr_of(k);
    if (n == 0) return 1'b0;
    if (a % n != 0) return 1'b1;
    if (a + n > MEMSZ) return 1'b1;
    return 1'b0;
  endfunction

  // Expected read data from the shadow memory. Sign extension is done by
  // subtracting 2^(8n) when the top bit is set.
  function automatic logic [31:0] read_val(input longint a, input logic [2:0] rd);
    int     n;
    longint v;
    n = nbytes(rd[1:0]);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(ref_mem[int'((a + i) % MEMSZ)]) << (8 * i));
    if (rd[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Which port the rules say is granted this cycle (-1 = none).
  function automatic int pick();
    if (rst) return -1;
    if (m_owner >= 0) return req_of(m_owner) ? m_owner : -1;
    if (m0_req && m1_req) begin
      if (m_wait[0] == MAXW) return 0;
      if (m_wait[1] == MAXW) return 1;
`ifdef DMEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    if (m0_req) return 0;
    if (m1_req) return 1;
    return -1;
  endfunction

  // Advance the reference model at each clock edge.
  always @(posedge clk) begin
    int     g;
    int     o;
    bit     e;
    int     nw [2];
    longint a;
    logic [1:0] wr;
    if (rst) begin
      m_owner = -1;
      m_wait  = '{0, 0};
      m_last  = 1;
      for (int k = 0; k < 2; k++) begin
        m_rvalid[k] = 1'b0;
        m_err[k]    = 1'b0;
        m_rdata[k]  = '0;
      end
      model_ready = 1'b1;
    end else if (model_ready) begin
      g = pick();
      e = (g >= 0) ? is_err(g) : 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (g == k) nw[k] = 0;
        else if (req_of(k)) nw[k] = (m_wait[k] + 1 > MAXW) ? MAXW : m_wait[k] + 1;
        else nw[k] = m_wait[k];
      end
      if (m_owner >= 0) begin
        o = 1 - m_owner;
        if (!req_of(m_owner) || (g == m_owner && !lock_of(m_owner)) ||
            (req_of(o) && nw[o] == MAXW)) m_owner = -1;
      end else if (g >= 0 && lock_of(g)) begin
        m_owner = g;
      end
      for (int k = 0; k < 2; k++) begin
        m_rvalid[k] = (g == k);
        m_err[k]    = (g == k) && e;
        if (g == k) begin
          a = 0;
          a[31:0] = addr_of(k);
          m_rdata[k] = (!e && nbytes(rd_of(k) & 3'b011) != 0) ? read_val(a, rd_of(k)) : 32'h0;
        end
      end
      if (g >= 0 && !e) begin
        wr = wr_of(g);
        a  = 0;
        a[31:0] = addr_of(g);
        for (int i = 0; i < nbytes(wr); i++)
          ref_mem[int'((a + i) % MEMSZ)] = wdata_of(g)[8*i +: 8];
      end
      if (g >= 0) m_last = g;
      m_wait = nw;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model at mid-cycle.
  always @(negedge clk) begin
    int          g;
    bit          e;
    logic [31:0] ea, ew;
    logic [2:0]  erd;
    logic [1:0]  ewr;
    if (model_ready) begin
      g = pick();
      e = (g >= 0) ? is_err(g) : 1'b0;
      ea = '0; ew = '0; erd = '0; ewr = '0;
      if (g >= 0) begin
        ea = addr_of(g);
        ew = wdata_of(g);
        if (!e) begin
          erd = rd_of(g);
          ewr = wr_of(g);
        end
      end
      checkOutput("m0_gnt", {31'b0, m0_gnt}, {31'b0, g == 0});
      checkOutput("m1_gnt", {31'b0, m1_gnt}, {31'b0, g == 1});
      checkOutput("dmem_addr", dmem_addr, ea);
      checkOutput("dmem_wdata", dmem_wdata, ew);
      checkOutput("dmem_rd", {29'b0, dmem_rd}, {29'b0, erd});
      checkOutput("dmem_wr", {30'b0, dmem_wr}, {30'b0, ewr});
      checkOutput("m0_rvalid", {31'b0, m0_rvalid}, {31'b0, m_rvalid[0]});
      checkOutput("m0_err", {31'b0, m0_err}, {31'b0, m_err[0]});
      checkOutput("m0_rdata", m0_rdata, m_rdata[0]);
      checkOutput("m1_rvalid", {31'b0, m1_rvalid}, {31'b0, m_rvalid[1]});
      checkOutput("m1_err", {31'b0, m1_err}, {31'b0, m_err[1]});
      checkOutput("m1_rdata", m1_rdata, m_rdata[1]);
    end
  end

  task automatic applyStimulus(input int port, input logic req, input logic lock,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] rd, input logic [1:0] wr);
    if (port == 0) begin
      m0_req = req; m0_lock = lock; m0_addr = addr; m0_wdata = wdata; m0_rd = rd; m0_wr = wr;
    end else begin
      m1_req = req; m1_lock = lock; m1_addr = addr; m1_wdata = wdata; m1_rd = rd; m1_wr = wr;
    end
  endtask

  task automatic idleAll();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] memWord(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  // Bound the run so that a stuck simulation still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int first;
    int n1;
    idleAll();
    rst = 1'b1;
    repeat (3) cycle();
    checkOutput("reset_m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    checkOutput("reset_m1_rdata", m1_rdata, 32'h0);
    rst = 1'b0;

    // Preload memory through the debug port.
    applyStimulus(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b000, 2'b11); cycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h11223344, 3'b000, 2'b11); cycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h3FC, 32'hCAFEF00D, 3'b000, 2'b11); cycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h5, 32'h00000080, 3'b000, 2'b01); cycle();
    idleAll(); cycle();
    checkOutput("preload_word", memWord(32'h10), 32'hDEADBEEF);

    // Word read with single-cycle latency.
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 2'b00);
    #1 checkOutput("t1_gnt", {31'b0, m0_gnt}, 32'h1);
    cycle(); idleAll();
    checkOutput("t1_rvalid", {31'b0, m0_rvalid}, 32'h1);
    checkOutput("t1_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("t1_err", {31'b0, m0_err}, 32'h0);
    cycle();

    // Both ports request every cycle.
    first = -1; n1 = 0;
    for (int i = 0; i < 34; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
      applyStimulus(1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
      #1;
      if (m1_gnt) begin
        n1++;
        if (first < 0) first = i;
      end
      cycle();
    end
    idleAll(); cycle();
`ifdef DMEM_ARB_RR_EN
    checkOutput("t2_first_m1", first, 0);
    checkOutput("t2_m1_count", n1, 17);
`else
    checkOutput("t2_first_m1", first, 16);
    checkOutput("t2_m1_count", n1, 2);
`endif

    // Locked burst of three M1 writes while M0 waits.
    applyStimulus(1, 1'b1, 1'b1, 32'h40, 32'h1, 3'b000, 2'b11);
    #1 checkOutput("t3_gnt1_a", {31'b0, m1_gnt}, 32'h1);
    cycle();
    applyStimulus(1, 1'b1, 1'b1, 32'h44, 32'h2, 3'b000, 2'b11);
    applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
    #1 checkOutput("t3_gnt1_b", {30'b0, m1_gnt, m0_gnt}, 32'h2);
    cycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h48, 32'h3, 3'b000, 2'b11);
    #1 checkOutput("t3_gnt1_c", {30'b0, m1_gnt, m0_gnt}, 32'h2);
    cycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
    #1 checkOutput("t3_gnt0_d", {30'b0, m1_gnt, m0_gnt}, 32'h1);
    cycle(); idleAll(); cycle();
    checkOutput("t3_mem44", memWord(32'h44), 32'h2);

    // M1 holds the lock forever; the starvation limit breaks it.
    applyStimulus(1, 1'b1, 1'b1, 32'h0, 32'h0, 3'b000, 2'b00);
    cycle();
    first = -1; n1 = 0;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
      #1;
      if (m0_gnt && first < 0) first = i;
      if (m1_gnt) n1++;
      cycle();
    end
    checkOutput("t4_m0_first_gnt", first, 17);
    checkOutput("t4_m1_gnts", n1, 16);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
    cycle(); idleAll(); cycle(); cycle();

    // Rejected and boundary accesses.
    applyStimulus(0, 1'b1, 1'b0, 32'h21, 32'hAAAA, 3'b000, 2'b10);
    #1 checkOutput("t5_half_dmem_wr", {30'b0, dmem_wr}, 32'h0);
    cycle();
    checkOutput("t5_half_rvalid", {31'b0, m0_rvalid}, 32'h1);
    checkOutput("t5_half_err", {31'b0, m0_err}, 32'h1);
    checkOutput("t5_mem_untouched", memWord(32'h20), 32'h11223344);
    applyStimulus(0, 1'b1, 1'b0, 32'h3FE, 32'h0, 3'b011, 2'b00); cycle();
    checkOutput("t5_word3fe_err", {31'b0, m0_err}, 32'h1);
    checkOutput("t5_word3fe_rdata", m0_rdata, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 3'b011, 2'b00); cycle();
    checkOutput("t5_word3fc_rdata", m0_rdata, 32'hCAFEF00D);
    checkOutput("t5_word3fc_err", {31'b0, m0_err}, 32'h0);
    applyStimulus(0, 1'b1, 1'b0, 32'h3FE, 32'h0, 3'b010, 2'b00); cycle();
    checkOutput("t5_half3fe_rdata", m0_rdata, 32'h0000CAFE);
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 3'b001, 2'b00); cycle();
    checkOutput("t5_byte400_err", {31'b0, m0_err}, 32'h1);
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0, 3'b000, 2'b00); cycle();
    checkOutput("t5_noop", {30'b0, m0_rvalid, m0_err}, 32'h2);

    // Sign-extended and zero-extended byte reads.
    applyStimulus(0, 1'b1, 1'b0, 32'h5, 32'h0, 3'b101, 2'b00); cycle();
    checkOutput("t6_byte_signed", m0_rdata, 32'hFFFFFF80);
    applyStimulus(0, 1'b1, 1'b0, 32'h5, 32'h0, 3'b001, 2'b00); cycle();
    checkOutput("t6_byte_unsigned", m0_rdata, 32'h00000080);

    // Reset in the middle of a lock and a write.
    idleAll();
    applyStimulus(1, 1'b1, 1'b1, 32'h0, 32'h0, 3'b000, 2'b00); cycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 2'b00);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 3'b000, 2'b11);
    rst = 1'b1;
    #1 checkOutput("t6_rst_dmem_wr", {30'b0, dmem_wr}, 32'h0);
    cycle();
    checkOutput("t6_rst_mem", memWord(32'h20), 32'h11223344);
    checkOutput("t6_rst_outputs", {m0_rvalid, m0_err, m1_rvalid, m1_err}, 32'h0);
    checkOutput("t6_rst_rdata", m0_rdata, 32'h0);
    rst = 1'b0;
    #1 checkOutput("t6_lock_released", {31'b0, m0_gnt}, 32'h1);
    cycle(); idleAll(); cycle();
    checkOutput("t6_write_after_rst", memWord(32'h20), 32'hFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
